// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction fetch unit
// Contents:
//   fetch_entry_t   : one prefetch buffer entry {pc, instr}
//   IFETCH_RESET_PC : default first fetch address after reset
package ifetch_pkg;

    localparam logic [31:0] IFETCH_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - DEPTH-entry prefetch buffer with synchronous flush
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   flush_i       : drop all entries this cycle (wins over push/pop)
//   push_i        : write push_data_i at tail (accepted when not full or popping)
//   push_data_i   : entry to write
//   pop_i         : remove head entry (ignored when empty)
//   head_o        : entry at head (undefined while empty)
//   empty_o/full_o: occupancy flags
module fetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_data_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign head_o  = mem_q[rd_ptr_q];

    // Push into a full buffer is legal only when the head leaves the same cycle.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with prefetch buffer and redirect
// Optional feature macro: IFETCH_HALT_ON_ZERO_EN (zero word stops fetch, sets halted)
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   imem_pc / imem_data         : word address out, combinational read data in
//   redirect_valid, redirect_pc : flush and restart fetch at redirect_pc
//   instr_valid/ready/data/pc   : instruction handshake towards decode
//   halted                      : fetch stopped on a terminator word
module instr_fetch
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFETCH_RESET_PC,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_pc,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_data,
    output logic [31:0] instr_pc,
    output logic        halted
);

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         run_q;
    logic         halted_int;
    logic         term;
    logic         fifo_empty, fifo_full;
    fetch_entry_t fifo_head, fetch_entry;
    logic         bypass, avail, pop, space, fetch_ok, push;
    logic         unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef IFETCH_HALT_ON_ZERO_EN
    logic halted_q, halted_d;

    assign term       = (imem_data == 32'h0);
    assign halted_int = halted_q;

    // Terminator only counts when the word would actually have been fetched.
    always_comb begin
        halted_d = halted_q;
        if (redirect_valid)
            halted_d = 1'b0;
        else if (run_q && !halted_q && space && term)
            halted_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) halted_q <= 1'b0;
        else        halted_q <= halted_d;
    end
`else
    assign term       = 1'b0;
    assign halted_int = 1'b0;
`endif

    assign halted      = halted_int;
    assign imem_pc     = fetch_pc_q;
    assign fetch_entry = '{pc: fetch_pc_q, instr: imem_data};

    // run_q holds off fetching for the first cycle after reset release, so the
    // first instruction appears one cycle later, matching redirect latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run_q <= 1'b0;
        else        run_q <= 1'b1;
    end

    // With an empty buffer the memory word falls straight through to decode;
    // this is what makes the redirect target visible the cycle after redirect.
    assign bypass      = fifo_empty && run_q && !halted_int && !term;
    assign avail       = !fifo_empty || bypass;
    assign instr_valid = avail && !redirect_valid;
    assign instr_pc    = !avail ? 32'h0 : (fifo_empty ? fetch_pc_q : fifo_head.pc);
    assign instr_data  = !avail ? 32'h0 : (fifo_empty ? imem_data  : fifo_head.instr);

    assign pop      = instr_valid && instr_ready;
    assign space    = !redirect_valid && (!fifo_full || pop);
    assign fetch_ok = run_q && !halted_int && space && !term;
    // A bypassed word consumed the same cycle is never stored.
    assign push     = fetch_ok && !(fifo_empty && pop);

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid)
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        else if (fetch_ok)
            fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fetch_pc_q <= {RESET_PC[31:2], 2'b00};
        else        fetch_pc_q <= fetch_pc_d;
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i (fetch_entry),
        .pop_i       (pop && !fifo_empty),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full)
    );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the prefetch buffer entry count; legal values 2..8.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port imem_pc, output, 32 bits, word address presented to instruction memory.
REQ-006 SHALL have port imem_data, input, 32 bits, combinational memory read of imem_pc, valid in the same cycle.
REQ-007 SHALL have port redirect_valid, input, 1 bit, a branch/jump redirect request.
REQ-008 SHALL have port redirect_pc, input, 32 bits, the redirect target.
REQ-009 SHALL have port instr_valid, output, 1 bit, a fetched instruction is available to decode.
REQ-010 SHALL have port instr_ready, input, 1 bit, decode accepts the instruction.
REQ-011 SHALL have port instr_data, output, 32 bits, the instruction word at buffer head.
REQ-012 SHALL have port instr_pc, output, 32 bits, the address of instr_data.
REQ-013 SHALL have port halted, output, 1 bit, fetch stopped on a terminator word.

Function
REQ-014 SHALL hold a fetch PC register; imem_pc SHALL equal it combinationally, bits [1:0] always 0.
REQ-015 SHALL push {fetch PC, imem_data} and advance fetch PC by 4 in a cycle when not halted, no redirect, and the buffer is not full or a pop occurs that cycle.
REQ-016 SHALL pop the head when instr_valid and instr_ready are both high; instr_valid = buffer non-empty and no redirect this cycle.
REQ-017 SHALL accept a simultaneous push and pop when full; count unchanged, order preserved.
REQ-018 SHALL keep instr_data/instr_pc stable while instr_valid is high and instr_ready is low.
REQ-019 SHALL, on redirect_valid, flush all entries, discard any pop that cycle, load fetch PC with {redirect_pc[31:2],2'b00}, clear halted, and push nothing that cycle.
REQ-020 SHALL present the redirect target instruction with instr_valid high exactly one cycle after the redirect cycle.
REQ-021 SHALL wrap fetch PC from 32'hFFFF_FFFC to 32'h0000_0000 without stalling.
REQ-022 SHALL present the first instruction (at RESET_PC) one cycle after rst_n deasserts; throughput 1 instruction per cycle when instr_ready is held high.

Reset
REQ-023 SHALL, while rst_n is low, set fetch PC = RESET_PC, buffer empty, instr_valid = 0, halted = 0, instr_data = 0, instr_pc = 0.
REQ-024 SHALL abandon any in-flight state on reset assertion mid-operation; no entry survives reset.

Configuration
REQ-025 SHALL, with macro IFETCH_HALT_ON_ZERO_EN defined, treat imem_data == 32'h0 as terminator: not pushed, fetch PC frozen, halted set next cycle and held until redirect or reset; buffered entries still drain.
REQ-026 SHALL, without IFETCH_HALT_ON_ZERO_EN, push a zero word as an ordinary instruction and tie halted to 0.

Structure
REQ-027 SHALL take the fetch-entry struct typedef (pc 32, instr 32) and the default reset-PC constant from a shared package ifetch_pkg.
REQ-028 SHALL implement the buffer as sub-module fetch_fifo (DEPTH-parameterised, synchronous flush, async active-low reset).

Verification
REQ-029 Reset release, RESET_PC=0, instr_ready=1, memory words 0..3 = 0x10025...: instr_pc 0x0,0x4,0x8,0xC on consecutive cycles starting cycle 1.
REQ-030 instr_ready=0 for 5 cycles with DEPTH=2 -> fetch PC stops at 0x8, head stays 0x0; on ready=1, three back-to-back pops, no gap.
REQ-031 Full buffer, redirect_valid with redirect_pc=0x0000_0103 -> next cycle instr_pc=0x100, no stale 0x0/0x4 entry ever accepted.
REQ-032 Redirect to 0xFFFF_FFF8, ready=1 -> instr_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
REQ-033 With IFETCH_HALT_ON_ZERO_EN, word at 0x10 = 0 -> 0x0..0xC delivered, 0x10 never valid, halted=1; redirect to 0x0 clears halted and refetches 0x0.
REQ-034 rst_n asserted mid-stream with entries buffered -> instr_valid=0 immediately; after release instr_pc=RESET_PC.
